// File: rtl/xmit_b.sv
// ---------------------------------------------------------------------------
// xmit_b -- FIFO-buffered serial transmitter.
//
// Words written through a valid/ready handshake are queued in a small FIFO.
// Each word is then sent as one frame: a start bit (0), DATA_W data bits
// LSB first, an optional even-parity bit, and a stop bit (1). Every bit is
// held for CLKS_PER_BIT cycles. When more words are queued, consecutive
// frames are separated by exactly one idle cycle.
//
// Build option: define XMIT_B_PARITY_EN to add an even-parity bit between
// the last data bit and the stop bit.
//
// Ports
//   xmit_b_clk        in   clock, all logic on the rising edge
//   xmit_b_rst        in   synchronous active-high reset
//   xmit_b_data_in    in   [DATA_W]  word to transmit
//   xmit_b_valid_in   in   xmit_b_data_in is valid
//   xmit_b_ready_out  out  FIFO can accept a word (low during reset)
//   xmit_b_ser_out    out  registered serial line, idle high
//   xmit_b_busy_out   out  a frame is in progress
//   xmit_b_count_out  out  [$clog2(DEPTH+1)]  words held in the FIFO
// ---------------------------------------------------------------------------
module xmit_b #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                       xmit_b_clk,
  input  logic                       xmit_b_rst,
  input  logic [DATA_W-1:0]          xmit_b_data_in,
  input  logic                       xmit_b_valid_in,
  output logic                       xmit_b_ready_out,
  output logic                       xmit_b_ser_out,
  output logic                       xmit_b_busy_out,
  output logic [$clog2(DEPTH+1)-1:0] xmit_b_count_out
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef XMIT_B_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  // Full is judged on the registered count only, so a pop in the same cycle
  // never opens the door early.
  assign xmit_b_ready_out = !xmit_b_rst && (count_reg < FULL);
  assign push             = xmit_b_valid_in && xmit_b_ready_out;
  assign head             = fifo_mem[rd_ptr_reg];
  assign xmit_b_count_out = count_reg;

  always_ff @(posedge xmit_b_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= xmit_b_data_in;
    end
  end

  always_ff @(posedge xmit_b_clk) begin
    if (xmit_b_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- Frame FSM ----------------
  state_t            state_reg, state_next;
  logic [CLK_W-1:0]  clk_cnt_reg, clk_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              ser_reg, ser_next;
  logic              last_clk;
`ifdef XMIT_B_PARITY_EN
  logic              par_reg, par_next;
`endif

  assign last_clk        = (clk_cnt_reg == CLK_LAST);
  assign xmit_b_ser_out  = ser_reg;
  assign xmit_b_busy_out = (state_reg != IDLE);

  always_ff @(posedge xmit_b_clk) begin
    if (xmit_b_rst) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      ser_reg     <= 1'b1;
`ifdef XMIT_B_PARITY_EN
      par_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      ser_reg     <= ser_next;
`ifdef XMIT_B_PARITY_EN
      par_reg     <= par_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    pop          = 1'b0;
`ifdef XMIT_B_PARITY_EN
    par_next     = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop          = 1'b1;
          shift_next   = head;
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = START;
`ifdef XMIT_B_PARITY_EN
          par_next     = ^head;
`endif
        end
      end
      START: begin
        if (last_clk) begin
          clk_cnt_next = '0;
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + CLK_W'(1);
        end
      end
      DATA: begin
        if (last_clk) begin
          clk_cnt_next = '0;
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_next = '0;
`ifdef XMIT_B_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            shift_next   = shift_reg >> 1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CLK_W'(1);
        end
      end
`ifdef XMIT_B_PARITY_EN
      PARITY: begin
        if (last_clk) begin
          clk_cnt_next = '0;
          state_next   = STOP;
        end else begin
          clk_cnt_next = clk_cnt_reg + CLK_W'(1);
        end
      end
`endif
      STOP: begin
        if (last_clk) begin
          clk_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          clk_cnt_next = clk_cnt_reg + CLK_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        clk_cnt_next = '0;
        bit_cnt_next = '0;
      end
    endcase

    // The line is registered from the upcoming state, so the start bit
    // appears on the same edge that pops the word.
    case (state_next)
      START:   ser_next = 1'b0;
      DATA:    ser_next = shift_next[0];
`ifdef XMIT_B_PARITY_EN
      PARITY:  ser_next = par_next;
`endif
      default: ser_next = 1'b1;
    endcase
  end

endmodule

// File: doc/xmit_b.md
XMIT_B -- requirements
Module: xmit_b

Interface
REQ-001 Parameter DATA_W, default 8, width of each transmitted word (>=1).
REQ-002 Parameter DEPTH, default 4, FIFO depth in words (power of 2, >=2).
REQ-003 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (>=1).
REQ-004 xmit_b_clk  in  1  single clock, all logic rising-edge.
REQ-005 xmit_b_rst  in  1  reset, synchronous, active-high.
REQ-006 xmit_b_data_in  in  DATA_W  word to transmit.
REQ-007 xmit_b_valid_in  in  1  xmit_b_data_in is valid.
REQ-008 xmit_b_ready_out  out  1  FIFO can accept a word.
REQ-009 xmit_b_ser_out  out  1  serial line, idle high, registered.
REQ-010 xmit_b_busy_out  out  1  frame in progress.
REQ-011 xmit_b_count_out  out  $clog2(DEPTH+1)  words held in FIFO.

Function
REQ-012 Word SHALL be accepted on an edge where valid_in=1 and ready_out=1; no other condition writes the FIFO.
REQ-013 ready_out SHALL be 1 when count_out<DEPTH and rst=0, else 0; at count_out==DEPTH it SHALL be 0 even if a pop occurs that cycle.
REQ-014 FIFO SHALL be first-in first-out; simultaneous push and pop SHALL leave count_out unchanged.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: ser_out=1; if count_out>0, SHALL pop head word into shift register and go to START on that edge.
REQ-017 START: ser_out=0 for CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: DATA_W bits LSB first, each CLKS_PER_BIT cycles; then PARITY (if enabled) else STOP.
REQ-019 STOP: ser_out=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-020 Latency: word accepted at edge k into empty FIFO with FSM in IDLE SHALL drive ser_out=0 from edge k+1.
REQ-021 Back-to-back frames SHALL be separated by exactly one IDLE cycle (ser_out=1).
REQ-022 busy_out SHALL be 1 in every state except IDLE.
REQ-023 Per-bit cycle counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit counter 0..DATA_W-1.
REQ-024 Frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.

Reset
REQ-025 While rst=1 at an edge: FSM->IDLE, FIFO emptied, count_out=0, ser_out=1, busy_out=0, all counters 0.
REQ-026 Reset mid-frame SHALL abort the frame; ser_out=1 from the next edge; flushed words are never transmitted.
REQ-027 ready_out SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro XMIT_B_PARITY_EN defined: PARITY state present, one bit of even parity (XOR of data bits) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-029 Macro XMIT_B_PARITY_EN undefined: no PARITY state or logic; DATA goes directly to STOP.

Verification
REQ-030 Reset: rst=1 for 3 cycles -> ser_out=1, busy_out=0, count_out=0, ready_out=0 during, 1 after release.
REQ-031 Defaults, no parity, push 0xA5 -> ser_out 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, 40 cycles total, busy_out=1 throughout.
REQ-032 Same with XMIT_B_PARITY_EN, push 0xA5 -> parity bit 0 inserted before stop, 44 cycles; 0x07 -> parity bit 1.
REQ-033 valid_in held with 6 words, FSM idle -> w1..w5 accepted on 5 consecutive edges, count_out reaches 4, ready_out=0, w6 accepted on the edge after the next pop; serial order w1..w6.
REQ-034 Two words queued -> exactly one ser_out=1 IDLE cycle between stop bit of frame 1 and start bit of frame 2.
REQ-035 rst pulsed in DATA state with 3 words queued -> ser_out=1 next edge, count_out=0, no further frames.
